mult_spi_sequencer: RTL and testbench
=====================================

Name: mult_spi_sequencer

Overview:
Frame-level sequencer for the SPI multiplier peripheral. It synchronizes the SPI pins into the system clock domain and deserializes two operands from MOSI. It then launches the shared multiplier, waits for completion with a timeout, and serializes the product back on MISO. It sits between the SPI pads and the multiplier datapath, replacing ad-hoc start/done wiring with a counted, abortable transaction.

Parameters:
OPW, 8, operand width in bits; one frame carries 2*OPW MOSI bits.
RESW, 16, product width in bits; equals 2*OPW.
TIMEOUT, 64, maximum clk cycles spent in MULT waiting for mult_done.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI serial clock, asynchronous to clk, period >= 8 clk
cs  input  1  chip select, active high, asynchronous
mosi  input  1  serial data in, MSB first
mult_res  input  RESW  multiplier product
mult_done  input  1  multiplier completion, level, sampled in MULT only
mult_a  output  OPW  operand A, held stable from MULT entry until next LOAD
mult_b  output  OPW  operand B, same hold rule
mult_start  output  1  one-clk pulse launching the multiplier
miso  output  1  serial data out, MSB first
busy  output  1  high in any state other than IDLE
err  output  1  timeout flag, sticky until cs is sampled low
state  output  3  current state encoding, for debug and the bench

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all shift registers, counters, mult_a, mult_b, mult_start, miso, err and busy cleared to 0.
  - Synchronizer flops cleared to 0.
- Synchronization:
  - sclk, cs and mosi each pass through a 2-flop synchronizer.
  - sclk_rise = synced sclk 0->1 between consecutive clk cycles; sclk_fall = synced sclk 1->0.
  - All decisions use synced signals only, so pin-to-action latency is 2-3 clk.
- State encodings: IDLE=0, LOAD=1, MULT=2, MULTRES=3, MISORESULT=4, ERR=5.
- IDLE:
  - Synced cs high -> LOAD; bitcnt=0, in_sr=0.
- LOAD:
  - On each sclk_rise: in_sr <= {in_sr, mosi_s}; bitcnt++.
  - On the rise where bitcnt==2*OPW-1: capture mult_a=in_sr upper OPW bits and mult_b=lower OPW bits, including the bit just sampled. Go to MULT.
  - mult_start=1 for exactly the first clk in MULT.
- MULT:
  - tocnt increments each clk from 0.
  - mult_done==1 -> MULTRES. If mult_done is already high on the mult_start cycle, it is honoured.
  - tocnt==TIMEOUT-1 without done -> ERR, err<=1.
  - If done and timeout occur on the same cycle, done wins.
- MULTRES (one clk):
  - out_sr <= mult_res; outcnt=0; go to MISORESULT.
- MISORESULT:
  - miso = out_sr MSB, driven from entry, so bit RESW-1 is valid before the first sclk_fall.
  - On each sclk_fall: shift out_sr left, fill with 0; outcnt++.
  - On the fall where outcnt==RESW-1 -> IDLE.
- ERR:
  - miso=0; stay until synced cs is low, then clear err and go to IDLE.
- Abort:
  - Synced cs low in LOAD, MULT, MULTRES or MISORESULT -> IDLE next clk; counters cleared.
  - mult_a and mult_b are retained. No mult_start is issued.
  - A later late mult_done is ignored.
  - Abort takes priority over any simultaneous sclk edge or done.
- Back-to-back frames:
  - cs still high on return to IDLE starts a new LOAD on the next clk.
  - Bits are counted only from sclk_rise events seen in LOAD.
- miso=0 in IDLE, LOAD, MULT and MULTRES.
- mult_start is never high outside the MULT-entry cycle.
- Width rule: product is taken as-is from mult_res; no truncation since RESW=2*OPW.

Test Plan:
- Basic frame: cs=1, shift 0x0C then 0x0A. Expect:
  - LOAD->MULT after the 16th rise, mult_a=0x0C, mult_b=0x0A, one mult_start pulse.
  - Model returns 0x0078 with done after 5 clk; MISORESULT.
  - 16 MISO bits read on sclk falls = 0x0078; then IDLE, busy=0.
- Timeout: withhold mult_done.
  - Expect ERR exactly TIMEOUT clk after mult_start, err=1, mult_start not repeated.
  - Drop cs: err=0, state=IDLE within 3 clk.
- Abort mid-LOAD: cs low after 5 bits.
  - Expect IDLE, no mult_start.
  - Next full frame 0xFF,0xFF yields mult_a=mult_b=0xFF and MISO 0xFE01.
- Abort in MISORESULT: cs low after 4 output bits.
  - Expect IDLE, miso=0.
  - Next frame 0x03,0x05 reads 0x000F cleanly.
- Done/timeout collision: assert mult_done on tocnt==TIMEOUT-1.
  - Expect MULTRES, err stays 0.
- Async reset: pull rst_n low mid-MULT.
  - All outputs 0 immediately, state=0; after release with cs high, a new frame works.

Source files
------------

// File: rtl/mult_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_spi_sequencer
//  Description : Frame-level sequencer for the SPI multiplier peripheral.
//                Brings SCLK/CS/MOSI into the clk domain, deserializes two
//                operands, launches the shared multiplier, waits for done
//                with a timeout, then serializes the product on MISO.
//  Ports       : clk, rst_n            - system clock, async active-low reset
//                sclk, cs, mosi        - raw SPI pins (asynchronous to clk)
//                mult_res, mult_done   - multiplier product and completion
//                mult_a, mult_b        - operands, held until the next LOAD
//                mult_start            - one-clk multiplier launch pulse
//                miso                  - serial product, MSB first
//                busy, err, state      - status and debug
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_spi_sequencer #(
    parameter int OPW     = 8,
    parameter int RESW    = 16,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sclk,
    input  logic            cs,
    input  logic            mosi,
    input  logic [RESW-1:0] mult_res,
    input  logic            mult_done,
    output logic [OPW-1:0]  mult_a,
    output logic [OPW-1:0]  mult_b,
    output logic            mult_start,
    output logic            miso,
    output logic            busy,
    output logic            err,
    output logic [2:0]      state
);

    localparam int c_BIT_CNT_W = $clog2(2*OPW);
    localparam int c_OUT_CNT_W = $clog2(RESW);
    localparam int c_TO_CNT_W  = $clog2(TIMEOUT) + 1;

    localparam logic [c_BIT_CNT_W-1:0] c_BIT_LAST = c_BIT_CNT_W'(2*OPW - 1);
    localparam logic [c_OUT_CNT_W-1:0] c_OUT_LAST = c_OUT_CNT_W'(RESW - 1);
    localparam logic [c_TO_CNT_W-1:0]  c_TO_LAST  = c_TO_CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_MULT       = 3'd2,
        S_MULTRES    = 3'd3,
        S_MISORESULT = 3'd4,
        S_ERR        = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Two-flop synchronizers; r_sclk_d holds the previous synced SCLK for
    // edge detection.
    logic r_sclk_meta, r_sclk_s, r_sclk_d;
    logic r_cs_meta,   r_cs_s;
    logic r_mosi_meta, r_mosi_s;

    logic w_sclk_rise;
    logic w_sclk_fall;

    // Only the first 2*OPW-1 bits need storing: the final bit is combined
    // with them directly at capture time.
    logic [2*OPW-2:0]       r_in_sr;
    logic [2*OPW-1:0]       w_in_next;
    logic [c_BIT_CNT_W-1:0] r_bitcnt;
    logic [c_TO_CNT_W-1:0]  r_tocnt;
    logic [RESW-1:0]        r_out_sr;
    logic [c_OUT_CNT_W-1:0] r_outcnt;
    logic [OPW-1:0]         r_mult_a;
    logic [OPW-1:0]         r_mult_b;
    logic                   r_err;

    assign w_sclk_rise = r_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s & r_sclk_d;
    assign w_in_next   = {r_in_sr, r_mosi_s};

    assign mult_a = r_mult_a;
    assign mult_b = r_mult_b;
    assign err    = r_err;
    assign state  = r_state;

    // ------------------------------------------------------------------
    // Synchronizers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_s    <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_cs_meta   <= 1'b0;
            r_cs_s      <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_s    <= 1'b0;
        end else begin
            r_sclk_meta <= sclk;
            r_sclk_s    <= r_sclk_meta;
            r_sclk_d    <= r_sclk_s;
            r_cs_meta   <= cs;
            r_cs_s      <= r_cs_meta;
            r_mosi_meta <= mosi;
            r_mosi_s    <= r_mosi_meta;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and outputs. A low CS is checked first in every active
    // state so an abort beats any coincident SCLK edge or mult_done.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        mult_start   = 1'b0;
        miso         = 1'b0;
        busy         = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                if (r_cs_s) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!r_cs_s) begin
                    w_state_next = S_IDLE;
                end else if (w_sclk_rise && (r_bitcnt == c_BIT_LAST)) begin
                    w_state_next = S_MULT;
                end
            end
            S_MULT: begin
                // The timeout counter is zero only on the entry cycle.
                mult_start = (r_tocnt == '0);
                if (!r_cs_s) begin
                    w_state_next = S_IDLE;
                end else if (mult_done) begin
                    w_state_next = S_MULTRES;
                end else if (r_tocnt == c_TO_LAST) begin
                    w_state_next = S_ERR;
                end
            end
            S_MULTRES: begin
                if (!r_cs_s) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_MISORESULT;
                end
            end
            S_MISORESULT: begin
                miso = r_out_sr[RESW-1];
                if (!r_cs_s) begin
                    w_state_next = S_IDLE;
                end else if (w_sclk_fall && (r_outcnt == c_OUT_LAST)) begin
                    w_state_next = S_IDLE;
                end
            end
            S_ERR: begin
                if (!r_cs_s) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Input shift register, bit counter and operand capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_sr  <= '0;
            r_bitcnt <= '0;
            r_mult_a <= '0;
            r_mult_b <= '0;
        end else if (r_state == S_LOAD) begin
            if (!r_cs_s) begin
                r_in_sr  <= '0;
                r_bitcnt <= '0;
            end else if (w_sclk_rise) begin
                r_in_sr  <= w_in_next[2*OPW-2:0];
                r_bitcnt <= r_bitcnt + 1'b1;
                if (r_bitcnt == c_BIT_LAST) begin
                    r_mult_a <= w_in_next[2*OPW-1:OPW];
                    r_mult_b <= w_in_next[OPW-1:0];
                end
            end
        end else begin
            r_in_sr  <= '0;
            r_bitcnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Timeout counter and sticky error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tocnt <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == S_MULT) && (w_state_next == S_MULT)) begin
                r_tocnt <= r_tocnt + 1'b1;
            end else begin
                r_tocnt <= '0;
            end

            if ((r_state == S_MULT) && (w_state_next == S_ERR)) begin
                r_err <= 1'b1;
            end else if ((r_state == S_ERR) && (w_state_next == S_IDLE)) begin
                r_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output shift register: loaded in MULTRES so the MSB is on MISO from
    // the first MISORESULT cycle, shifted on each synced SCLK fall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_sr <= '0;
            r_outcnt <= '0;
        end else if ((r_state == S_MULTRES) && (w_state_next == S_MISORESULT)) begin
            r_out_sr <= mult_res;
            r_outcnt <= '0;
        end else if (r_state == S_MISORESULT) begin
            if (w_state_next != S_MISORESULT) begin
                r_out_sr <= '0;
                r_outcnt <= '0;
            end else if (w_sclk_fall) begin
                r_out_sr <= {r_out_sr[RESW-2:0], 1'b0};
                r_outcnt <= r_outcnt + 1'b1;
            end
        end else begin
            r_out_sr <= '0;
            r_outcnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_spi_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_spi_sequencer
//  Description : Directed self-checking bench for mult_spi_sequencer with a
//                behavioural multiplier and an operand/product scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_spi_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sclk;
    logic        cs;
    logic        mosi;
    logic [15:0] mult_res;
    logic        mult_done;
    logic [7:0]  mult_a;
    logic [7:0]  mult_b;
    logic        mult_start;
    logic        miso;
    logic        busy;
    logic        err;
    logic [2:0]  state;

    mult_spi_sequencer #(
        .OPW     (8),
        .RESW    (16),
        .TIMEOUT (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs         (cs),
        .mosi       (mosi),
        .mult_res   (mult_res),
        .mult_done  (mult_done),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_start (mult_start),
        .miso       (miso),
        .busy       (busy),
        .err        (err),
        .state      (state)
    );

    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int err_cyc   = 0;
    logic [2:0] prev_state = 3'd0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } item_t;

    item_t exp_q[$];
    item_t cur;

    // Cycle monitor, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (mult_start === 1'b1) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if (state === 3'd5 && prev_state !== 3'd5) begin
            err_cyc = cyc;
        end
        prev_state = state;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive the first n bits of w, MSB first; data set 6 clk before each rise.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = w[15-i];
            clocks(6);
            sclk = 1'b1;
            clocks(6);
            sclk = 1'b0;
        end
    endtask

    task automatic start_frame(input logic [7:0] a, input logic [7:0] b);
        item_t it;
        it.a = a;
        it.b = b;
        it.p = 16'(a) * 16'(b);
        exp_q.push_back(it);
        cs = 1'b1;
        clocks(4);
        send_bits({a, b}, 16);
    endtask

    task automatic check_ops(input int start_before);
        cur = exp_q.pop_front();
        check("single_start", 32'(start_cnt), 32'(start_before + 1));
        check("in_mult", 32'(state), 32'd2);
        check("mult_a", 32'(mult_a), 32'(cur.a));
        check("mult_b", 32'(mult_b), 32'(cur.b));
    endtask

    // Behavioural multiplier: done pulse 'delay' clk after mult_start.
    task automatic give_done(input int delay);
        for (int k = 0; k < 200 && cyc < start_cyc + delay; k++) @(negedge clk);
        check("done_align", 32'(cyc), 32'(start_cyc + delay));
        mult_res  = 16'(mult_a) * 16'(mult_b);
        mult_done = 1'b1;
        @(negedge clk);
        mult_done = 1'b0;
        check("to_multres", 32'(state), 32'd3);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
        for (int k = 0; k < budget && state !== s; k++) @(negedge clk);
        check(tag, 32'(state), 32'(s));
    endtask

    // Sample MISO before each falling SCLK edge; optionally drop CS one clk
    // after the last fall so the frame completes without an immediate restart.
    task automatic read_bits(input int n, input bit drop_cs, output logic [15:0] got);
        got = 16'h0;
        for (int i = 0; i < n; i++) begin
            got  = {got[14:0], miso};
            sclk = 1'b1;
            clocks(6);
            sclk = 1'b0;
            if (drop_cs && i == n - 1) begin
                clocks(1);
                cs = 1'b0;
                clocks(5);
            end else begin
                clocks(6);
            end
        end
    endtask

    initial begin
        logic [15:0] got;
        int          sb;

        rst_n     = 1'b0;
        sclk      = 1'b0;
        cs        = 1'b0;
        mosi      = 1'b0;
        mult_done = 1'b0;
        mult_res  = 16'h0;
        clocks(3);
        check("reset_state", 32'(state), 32'd0);
        check("reset_outs", 32'({busy, err, mult_start, miso, mult_a, mult_b}), 32'd0);
        rst_n = 1'b1;
        clocks(2);

        // Basic frame 0x0C * 0x0A
        sb = start_cnt;
        start_frame(8'h0C, 8'h0A);
        check_ops(sb);
        give_done(5);
        wait_state("basic_misores", 3'd4, 5);
        read_bits(16, 1'b1, got);
        check("basic_miso", 32'(got), 32'(cur.p));
        check("basic_idle", 32'(state), 32'd0);
        check("basic_busy", 32'(busy), 32'd0);
        check("basic_one_start", 32'(start_cnt), 32'(sb + 1));
        clocks(4);

        // Timeout: no done
        sb = start_cnt;
        start_frame(8'h21, 8'h43);
        check_ops(sb);
        wait_state("to_err", 3'd5, 100);
        check("to_latency", 32'(err_cyc - start_cyc), 32'd64);
        check("err_flag", 32'(err), 32'd1);
        check("err_miso", 32'(miso), 32'd0);
        check("no_restart", 32'(start_cnt), 32'(sb + 1));
        cs = 1'b0;
        clocks(3);
        check("err_cleared", 32'(err), 32'd0);
        check("err_to_idle", 32'(state), 32'd0);
        clocks(2);

        // Abort mid-LOAD after 5 bits
        sb = start_cnt;
        cs = 1'b1;
        clocks(4);
        send_bits(16'hB6D3, 5);
        cs = 1'b0;
        clocks(4);
        check("abort_load_idle", 32'(state), 32'd0);
        check("abort_load_nostart", 32'(start_cnt), 32'(sb));
        clocks(2);
        sb = start_cnt;
        start_frame(8'hFF, 8'hFF);
        check_ops(sb);
        give_done(5);
        wait_state("ff_misores", 3'd4, 5);
        read_bits(16, 1'b1, got);
        check("ff_miso", 32'(got), 32'(cur.p));
        clocks(4);

        // Abort in MISORESULT after 4 output bits
        sb = start_cnt;
        start_frame(8'h5A, 8'h3C);
        check_ops(sb);
        give_done(5);
        wait_state("abort_out_misores", 3'd4, 5);
        read_bits(4, 1'b0, got);
        cs = 1'b0;
        clocks(4);
        check("abort_out_idle", 32'(state), 32'd0);
        check("abort_out_miso", 32'(miso), 32'd0);
        check("abort_out_bits", 32'(got), 32'(cur.p[15:12]));
        clocks(2);
        sb = start_cnt;
        start_frame(8'h03, 8'h05);
        check_ops(sb);
        give_done(5);
        wait_state("f35_misores", 3'd4, 5);
        read_bits(16, 1'b1, got);
        check("f35_miso", 32'(got), 32'(cur.p));
        clocks(4);

        // Done coinciding with the last timeout cycle
        sb = start_cnt;
        start_frame(8'h07, 8'h09);
        check_ops(sb);
        give_done(63);
        check("collide_no_err", 32'(err), 32'd0);
        wait_state("collide_misores", 3'd4, 5);
        read_bits(16, 1'b1, got);
        check("collide_miso", 32'(got), 32'(cur.p));
        clocks(4);

        // Asynchronous reset in MULT
        sb = start_cnt;
        start_frame(8'h12, 8'h34);
        check_ops(sb);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_outs", 32'({busy, err, mult_start, miso, mult_a, mult_b}), 32'd0);
        clocks(2);
        rst_n = 1'b1;
        sb = start_cnt;
        start_frame(8'h12, 8'h34);
        check_ops(sb);
        give_done(5);
        wait_state("post_rst_misores", 3'd4, 5);
        read_bits(16, 1'b1, got);
        check("post_rst_miso", 32'(got), 32'(cur.p));
        clocks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
